// File: rtl/pkt_stream_player.sv
// -----------------------------------------------------------------------------
// pkt_stream_player
//
// Buffers whole packets that arrive one byte at a time and replays each one as
// a stream of WIN_BYTES-wide beats (valid/sop/eop/empty) under ready
// backpressure. Up to PKT_SLOTS complete packets are queued in a slot ring.
// A programmable idle gap follows every packet. Packets longer than
// MAX_PKT_BYTES are dropped and raise a sticky error flag.
//
// Ports:
//   clk           single clock
//   reset         synchronous, active-high; dominates all other inputs
//   load_valid    load byte valid
//   load_ready    load byte accepted when load_valid & load_ready
//   load_data     packet byte, in wire order
//   load_last     final byte of the packet
//   out_valid     output beat valid
//   out_ready     downstream ready
//   out_data      beat bytes; packet byte offset+i on bits [8i+7:8i]
//   out_sop       first beat of a packet
//   out_eop       last beat of a packet
//   out_empty     unused bytes on the eop beat, 0 on every other beat
//   cfg_gap       idle cycles added after each eop; sampled when eop is accepted
//   err_oversize  sticky; a load ran past MAX_PKT_BYTES
//   pkt_sent_cnt  packets fully transmitted; wraps at 2^16
// -----------------------------------------------------------------------------
module pkt_stream_player #(
    parameter int WIN_BYTES     = 16,
    parameter int MAX_PKT_BYTES = 1518,
    parameter int PKT_SLOTS     = 4,
    parameter int GAP_W         = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [7:0]                   load_data,
    input  logic                         load_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [8*WIN_BYTES-1:0]       out_data,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [$clog2(WIN_BYTES)-1:0] out_empty,
    input  logic [GAP_W-1:0]             cfg_gap,
    output logic                         err_oversize,
    output logic [15:0]                  pkt_sent_cnt
);

    localparam int LOG_W  = $clog2(WIN_BYTES);
    localparam int WORDS  = (MAX_PKT_BYTES + WIN_BYTES - 1) / WIN_BYTES;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    // One spare bit so the write index can hold MAX_PKT_BYTES itself,
    // which is the value that flags an oversize packet.
    localparam int IDX_W  = LOG_W + WORD_W + 1;
    localparam int PTR_W  = (PKT_SLOTS > 1) ? $clog2(PKT_SLOTS) : 1;
    localparam int OCC_W  = $clog2(PKT_SLOTS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Packet storage: each slot is a column of window-wide words, so one read
    // yields a whole output beat; the load path writes a single byte lane.
    logic [8*WIN_BYTES-1:0] mem      [PKT_SLOTS][WORDS];
    logic [15:0]            slot_len [PKT_SLOTS];

    logic [1:0]        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [IDX_W-1:0]  wr_idx;
    logic              dropping;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WORD_W-1:0] rd_word;

    logic              load_fire;
    logic              at_max;
    logic              store;
    logic              commit;
    logic              free;

    logic [WORD_W-1:0]      nxt_word;
    logic [16:0]            cur_len;
    logic [16:0]            beat_off;
    logic [16:0]            beat_end;
    logic [16:0]            beat_diff;
    logic [8*WIN_BYTES-1:0] raw_word;
    logic [8*WIN_BYTES-1:0] beat_data;
    logic                   beat_eop;
    logic [LOG_W-1:0]       beat_empty;

    // Readiness comes from the registered occupancy only, so a commit and a
    // free landing on the same edge never make load_ready combinationally
    // depend on out_ready.
    assign load_ready = !reset && (occ < OCC_W'(PKT_SLOTS));
    assign load_fire  = load_valid && load_ready;
    assign at_max     = (wr_idx == IDX_W'(MAX_PKT_BYTES));
    assign store      = load_fire && !dropping && !at_max;
    assign commit     = store && load_last;
    assign free       = out_valid && out_ready && out_eop;

    // NOTE: the packet buffer has no reset; its contents are only ever read
    // through a committed slot length, so stale bytes are never exposed and
    // the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr][wr_idx[LOG_W +: WORD_W]][{wr_idx[LOG_W-1:0], 3'b000} +: 8] <= load_data;
        end
        if (commit) begin
            slot_len[wr_ptr] <= 16'(wr_idx) + 16'd1;
        end
    end

    // Next beat to present: word 0 of the head slot when leaving IDLE,
    // otherwise the word after the one currently on the output.
    // NOTE: every signal driven here gets a value before any condition,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        nxt_word   = (state == ST_SEND) ? rd_word + WORD_W'(1) : '0;
        cur_len    = {1'b0, slot_len[rd_ptr]};
        raw_word   = mem[rd_ptr][nxt_word];
        beat_off   = 17'(nxt_word) << LOG_W;
        // 17-bit arithmetic keeps offset + window from wrapping near 64 KiB.
        beat_end   = beat_off + 17'(WIN_BYTES);
        beat_diff  = beat_end - cur_len;
        beat_eop   = (beat_end >= cur_len);
        beat_empty = beat_eop ? beat_diff[LOG_W-1:0] : '0;
        beat_data  = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            // Bytes past the packet end are forced to zero; the RAM there
            // still holds whatever an earlier packet left behind.
            if ((beat_off + 17'(i)) < cur_len) begin
                beat_data[8*i +: 8] = raw_word[8*i +: 8];
            end
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values, e.g. occ for commit and free together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            wr_idx       <= '0;
            dropping     <= 1'b0;
            gap_cnt      <= '0;
            rd_word      <= '0;
            out_valid    <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_empty    <= '0;
            out_data     <= '0;
            err_oversize <= 1'b0;
            pkt_sent_cnt <= '0;
        end else begin
            // Load side. An oversize packet is swallowed through its last
            // byte without committing a slot.
            if (load_fire) begin
                if (dropping) begin
                    if (load_last) begin
                        dropping <= 1'b0;
                    end
                end else if (at_max) begin
                    err_oversize <= 1'b1;
                    wr_idx       <= '0;
                    dropping     <= !load_last;
                end else if (load_last) begin
                    wr_idx <= '0;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end

            if (commit && !free) begin
                occ <= occ + OCC_W'(1);
            end else if (free && !commit) begin
                occ <= occ - OCC_W'(1);
            end

            if (free) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (occ != '0) begin
                        out_valid <= 1'b1;
                        out_sop   <= 1'b1;
                        out_eop   <= beat_eop;
                        out_empty <= beat_empty;
                        out_data  <= beat_data;
                        rd_word   <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Nothing moves while the beat is stalled.
                    if (out_ready) begin
                        if (out_eop) begin
                            out_valid <= 1'b0;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b0;
                            out_empty <= '0;
                            out_data  <= '0;
                            if (cfg_gap == '0) begin
                                state <= ST_IDLE;
                            end else begin
                                gap_cnt <= cfg_gap;
                                state   <= ST_GAP;
                            end
                        end else begin
                            rd_word   <= nxt_word;
                            out_sop   <= 1'b0;
                            out_eop   <= beat_eop;
                            out_empty <= beat_empty;
                            out_data  <= beat_data;
                        end
                    end
                end
                ST_GAP: begin
                    // IDLE always adds one more cycle, so G here yields G+1
                    // idle cycles between eop accept and the next sop.
                    if (gap_cnt <= GAP_W'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_stream_player.sv
// -----------------------------------------------------------------------------
// tb_pkt_stream_player
//
// Directed bench for pkt_stream_player with the default parameters
// (16-byte window, 1518-byte packets, 4 slots, 8-bit gap). Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_pkt_stream_player;

    localparam int WIN = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [7:0]   load_data;
    logic         load_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_sop;
    logic         out_eop;
    logic [3:0]   out_empty;
    logic [7:0]   cfg_gap;
    logic         err_oversize;
    logic [15:0]  pkt_sent_cnt;

    int checks   = 0;
    int failures = 0;
    int timeouts = 0;

    logic [127:0] cap_data  [128];
    logic         cap_sop   [128];
    logic         cap_eop   [128];
    logic [3:0]   cap_empty [128];

    pkt_stream_player #(
        .WIN_BYTES    (16),
        .MAX_PKT_BYTES(1518),
        .PKT_SLOTS    (4),
        .GAP_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_empty   (out_empty),
        .cfg_gap     (cfg_gap),
        .err_oversize(err_oversize),
        .pkt_sent_cnt(pkt_sent_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // Reference beat: packet byte j is (base + j) & 0xFF, zero past the end.
    function automatic logic [127:0] exp_beat(input int len, input int base, input int off);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < WIN; i++) begin
            if (off + i < len) d[8*i +: 8] = 8'((base + off + i) & 255);
        end
        return d;
    endfunction

    // Loads one packet; bounded wait on load_ready for every byte.
    task automatic load_pkt(input int len, input int base);
        int  wait_n;
        bit  stuck;
        stuck = 1'b0;
        for (int i = 0; i < len && !stuck; i++) begin
            load_valid = 1'b1;
            load_data  = 8'((base + i) & 255);
            load_last  = (i == len - 1);
            wait_n     = 0;
            while (load_ready !== 1'b1 && wait_n < 200) begin
                @(negedge clk);
                wait_n++;
            end
            if (load_ready !== 1'b1) begin
                stuck = 1'b1;
                timeouts++;
            end else begin
                @(negedge clk);
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Receives one packet into cap_*; bp selects ready pattern 1,0,0,1,0,0...
    task automatic capture_pkt(input bit bp, output int nbeats, output int first_valid,
                               output bit hold_err);
        int           cyc;
        bit           done;
        bit           held;
        logic [127:0] hd;
        logic         hs, he;
        logic [3:0]   hm;
        cyc = 0; done = 1'b0; held = 1'b0;
        hd = '0; hs = 1'b0; he = 1'b0; hm = '0;
        nbeats = 0; first_valid = -1; hold_err = 1'b0;
        while (!done && cyc < 500) begin
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (out_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (held && (out_data !== hd || out_sop !== hs || out_eop !== he || out_empty !== hm))
                    hold_err = 1'b1;
                if (out_ready) begin
                    if (nbeats < 128) begin
                        cap_data[nbeats]  = out_data;
                        cap_sop[nbeats]   = out_sop;
                        cap_eop[nbeats]   = out_eop;
                        cap_empty[nbeats] = out_empty;
                    end
                    nbeats++;
                    held = 1'b0;
                    if (out_eop === 1'b1) done = 1'b1;
                end else begin
                    held = 1'b1;
                    hd = out_data; hs = out_sop; he = out_eop; hm = out_empty;
                end
            end else if (held) begin
                hold_err = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) timeouts++;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        out_ready = 1'b0; cfg_gap = '0;
        repeat (3) @(negedge clk);
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
        checks++; if ({out_valid, out_sop, out_eop} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {out_valid, out_sop, out_eop}); end
        checks++; if (out_data !== 128'd0 || out_empty !== 4'd0) begin failures++; $display("FAIL reset_data: got %h/%0d want 0/0", out_data, out_empty); end
        checks++; if (err_oversize !== 1'b0 || pkt_sent_cnt !== 16'd0) begin failures++; $display("FAIL reset_status: got %b/%0d want 0/0", err_oversize, pkt_sent_cnt); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL post_reset_load_ready: got %b want 1", load_ready); end
    endtask

    task automatic test_single_pkt();
        int n, fv; bit he;
        load_pkt(60, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_latency_early: got %b want 0", out_valid); end
        capture_pkt(1'b0, n, fv, he);
        checks++; if (fv !== 1) begin failures++; $display("FAIL single_latency: first valid at %0d want 1", fv); end
        checks++; if (n !== 4) begin failures++; $display("FAIL single_nbeats: got %0d want 4", n); end
        checks++; if (cap_sop[0] !== 1'b1 || cap_data[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin failures++; $display("FAIL single_beat0: got sop=%b %h", cap_sop[0], cap_data[0]); end
        checks++; if (cap_eop[3] !== 1'b1 || cap_empty[3] !== 4'd4 || cap_data[3] !== 128'h00000000_3B3A3938_37363534_33323130) begin failures++; $display("FAIL single_beat3: got eop=%b empty=%0d %h want 1/4", cap_eop[3], cap_empty[3], cap_data[3]); end
        for (int b = 1; b < 3; b++) begin
            checks++; if (cap_sop[b] !== 1'b0 || cap_eop[b] !== 1'b0 || cap_empty[b] !== 4'd0 || cap_data[b] !== exp_beat(60, 0, 16*b)) begin failures++; $display("FAIL single_mid_beat%0d: got %b%b %0d %h", b, cap_sop[b], cap_eop[b], cap_empty[b], cap_data[b]); end
        end
        checks++; if (pkt_sent_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt: got %0d want 1", pkt_sent_cnt); end
    endtask

    task automatic test_backpressure();
        int n, fv; bit he;
        load_pkt(60, 8'h40);
        capture_pkt(1'b1, n, fv, he);
        checks++; if (n !== 4) begin failures++; $display("FAIL bp_nbeats: got %0d want 4", n); end
        checks++; if (he !== 1'b0) begin failures++; $display("FAIL bp_hold_stable: got %b want 0", he); end
        for (int b = 0; b < 4; b++) begin
            checks++; if (cap_data[b] !== exp_beat(60, 8'h40, 16*b) || cap_sop[b] !== (b == 0) || cap_eop[b] !== (b == 3)) begin failures++; $display("FAIL bp_beat%0d: got %b%b %h", b, cap_sop[b], cap_eop[b], cap_data[b]); end
        end
        checks++; if (cap_empty[3] !== 4'd4) begin failures++; $display("FAIL bp_empty: got %0d want 4", cap_empty[3]); end
        checks++; if (pkt_sent_cnt !== 16'd2) begin failures++; $display("FAIL bp_cnt: got %0d want 2", pkt_sent_cnt); end
    endtask

    task automatic test_full_buffer();
        int n, fv, cyc; bit he, eop_seen; logic [7:0] tag1;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) load_pkt(64, k);
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready_drop: got %b want 0", load_ready); end
        out_ready = 1'b1; eop_seen = 1'b0; cyc = 0; tag1 = 8'hxx;
        while (!eop_seen && cyc < 40) begin
            if (out_valid === 1'b1 && out_sop === 1'b1) tag1 = out_data[7:0];
            if (out_valid === 1'b1 && out_eop === 1'b1) begin
                eop_seen = 1'b1;
                checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready_at_eop: got %b want 0", load_ready); end
            end
            @(negedge clk);
            cyc++;
        end
        if (!eop_seen) timeouts++;
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL full_ready_return: got %b want 1", load_ready); end
        checks++; if (tag1 !== 8'd1) begin failures++; $display("FAIL full_tag1: got %h want 01", tag1); end
        out_ready = 1'b0;
        load_pkt(64, 5);
        for (int k = 2; k <= 5; k++) begin
            capture_pkt(1'b0, n, fv, he);
            checks++; if (n !== 4 || cap_data[0][7:0] !== 8'(k)) begin failures++; $display("FAIL full_pkt%0d: got beats=%0d tag=%h want 4/%0d", k, n, cap_data[0][7:0], k); end
            checks++; if (cap_data[3] !== exp_beat(64, k, 48) || cap_eop[3] !== 1'b1 || cap_empty[3] !== 4'd0) begin failures++; $display("FAIL full_last%0d: got eop=%b empty=%0d %h", k, cap_eop[3], cap_empty[3], cap_data[3]); end
        end
        checks++; if (pkt_sent_cnt !== 16'd7) begin failures++; $display("FAIL full_cnt: got %0d want 7", pkt_sent_cnt); end
    endtask

    task automatic test_gap();
        int acc_cyc [2];
        logic [127:0] acc_data [2];
        logic [5:0] acc_flags [2];
        int nacc, cyc;
        cfg_gap = 8'd3; out_ready = 1'b0;
        load_pkt(16, 8'hA0);
        load_pkt(16, 8'hB0);
        out_ready = 1'b1; nacc = 0; cyc = 0;
        while (nacc < 2 && cyc < 40) begin
            if (out_valid === 1'b1) begin
                acc_cyc[nacc] = cyc; acc_data[nacc] = out_data;
                acc_flags[nacc] = {out_sop, out_eop, out_empty};
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        cfg_gap = 8'd0;
        checks++; if (nacc !== 2) begin failures++; $display("FAIL gap_naccept: got %0d want 2", nacc); end
        else begin
            checks++; if (acc_cyc[1] - acc_cyc[0] - 1 !== 4) begin failures++; $display("FAIL gap_idle: got %0d want 4", acc_cyc[1] - acc_cyc[0] - 1); end
            checks++; if (acc_flags[0] !== 6'b110000 || acc_flags[1] !== 6'b110000) begin failures++; $display("FAIL gap_flags: got %b %b want 110000", acc_flags[0], acc_flags[1]); end
            checks++; if (acc_data[0] !== exp_beat(16, 8'hA0, 0) || acc_data[1] !== exp_beat(16, 8'hB0, 0)) begin failures++; $display("FAIL gap_data: got %h %h", acc_data[0], acc_data[1]); end
        end
        checks++; if (pkt_sent_cnt !== 16'd9) begin failures++; $display("FAIL gap_cnt: got %0d want 9", pkt_sent_cnt); end
    endtask

    task automatic test_oversize();
        int n, fv, vcnt; bit he;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        load_pkt(1601, 0);
        checks++; if (err_oversize !== 1'b1) begin failures++; $display("FAIL ovs_flag: got %b want 1", err_oversize); end
        vcnt = 0;
        repeat (5) begin
            if (out_valid !== 1'b0) vcnt++;
            @(negedge clk);
        end
        checks++; if (vcnt !== 0) begin failures++; $display("FAIL ovs_no_emit: got %0d valid cycles want 0", vcnt); end
        load_pkt(64, 8'h55);
        capture_pkt(1'b0, n, fv, he);
        checks++; if (n !== 4 || cap_sop[0] !== 1'b1 || cap_data[0] !== exp_beat(64, 8'h55, 0)) begin failures++; $display("FAIL ovs_next_pkt: got beats=%0d %h", n, cap_data[0]); end
        checks++; if (pkt_sent_cnt !== 16'd1 || err_oversize !== 1'b1) begin failures++; $display("FAIL ovs_status: got cnt=%0d err=%b want 1/1", pkt_sent_cnt, err_oversize); end
    endtask

    task automatic test_reset_mid_pkt();
        int n, fv, nacc, cyc, vcnt; bit he, hit;
        out_ready = 1'b0;
        load_pkt(128, 0);
        load_pkt(64, 8'h80);
        out_ready = 1'b1; nacc = 0; cyc = 0; hit = 1'b0;
        while (!hit && cyc < 40) begin
            if (out_valid === 1'b1) begin
                if (nacc == 2) hit = 1'b1;
                else nacc++;
            end
            if (!hit) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!hit) timeouts++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || load_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_out: got valid=%b ready=%b want 0/0", out_valid, load_ready); end
        checks++; if (err_oversize !== 1'b0 || pkt_sent_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_status: got err=%b cnt=%0d want 0/0", err_oversize, pkt_sent_cnt); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b want 1", load_ready); end
        vcnt = 0;
        repeat (8) begin
            if (out_valid !== 1'b0) vcnt++;
            @(negedge clk);
        end
        checks++; if (vcnt !== 0) begin failures++; $display("FAIL rst_mid_slots_freed: got %0d valid cycles want 0", vcnt); end
        load_pkt(60, 8'h10);
        capture_pkt(1'b0, n, fv, he);
        checks++; if (n !== 4 || cap_sop[0] !== 1'b1 || cap_data[0] !== exp_beat(60, 8'h10, 0)) begin failures++; $display("FAIL rst_mid_restart: got beats=%0d sop=%b %h", n, cap_sop[0], cap_data[0]); end
        checks++; if (cap_eop[3] !== 1'b1 || cap_empty[3] !== 4'd4 || cap_data[3] !== exp_beat(60, 8'h10, 48)) begin failures++; $display("FAIL rst_mid_last: got eop=%b empty=%0d %h", cap_eop[3], cap_empty[3], cap_data[3]); end
        checks++; if (pkt_sent_cnt !== 16'd1) begin failures++; $display("FAIL rst_mid_cnt: got %0d want 1", pkt_sent_cnt); end
    endtask

    task automatic test_timeouts();
        checks++; if (timeouts !== 0) begin failures++; $display("FAIL bounded_waits: got %0d expired waits want 0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_backpressure();
        test_full_buffer();
        test_gap();
        test_oversize();
        test_reset_mid_pkt();
        test_timeouts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_stream_player.md
Name: pkt_stream_player

Overview:
- Synthesisable successor to the file-driven Ethernet packet stimulus: buffers whole packets loaded byte-wise and replays them as windowed ch_pkt_stream beats (valid/sop/eop) into the parser, under full ready backpressure.
- Generalised in window width, packet depth and slot count.
- Adds behaviour the file-driven source lacks:
  - last-beat byte count (empty);
  - programmable inter-packet gap;
  - oversize-packet detection.
- Sits between the capture/DMA side and snort_top's ch_pkt_stream_eth_in.

Parameters:
- WIN_BYTES, 16, bytes per output beat; power of 2, ≥2.
- MAX_PKT_BYTES, 1518, maximum stored packet length in bytes.
- PKT_SLOTS, 4, packets buffered; power of 2.
- GAP_W, 8, width of cfg_gap.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- load_valid  in  1  load byte valid
- load_ready  out  1  load byte accepted when valid&ready
- load_data  in  8  packet byte, in wire order
- load_last  in  1  final byte of packet
- out_valid  out  1  beat valid
- out_ready  in  1  downstream ready
- out_data  out  8*WIN_BYTES  byte offset+i on bits [8i+7:8i]
- out_sop  out  1  first beat of packet
- out_eop  out  1  last beat of packet
- out_empty  out  $clog2(WIN_BYTES)  unused bytes on eop beat; 0 otherwise
- cfg_gap  in  GAP_W  idle cycles inserted after each eop; sampled at eop acceptance
- err_oversize  out  1  sticky; set when a load exceeds MAX_PKT_BYTES
- pkt_sent_cnt  out  16  packets fully transmitted; wraps

Behaviour:
- Reset: sync, active-high; dominates all other inputs. Effects:
  - out_valid/sop/eop=0, out_empty=0, out_data=0;
  - load_ready=0 during reset, 1 on the first cycle after;
  - err_oversize=0, pkt_sent_cnt=0;
  - all slots freed; partial load discarded; FSM=IDLE.
  - Reset mid-packet truncates the stream; no eop is emitted.
- Slot ring:
  - write pointer, read pointer, occupancy 0..PKT_SLOTS; per-slot 16-bit length.
  - load_ready = (occupancy < PKT_SLOTS) and not in reset.
- Load path:
  - Each accepted byte is written at wr_byte_idx, which then increments.
  - load_last accepted: slot length = idx+1; slot committed (wr ptr++, occupancy++) at that edge; idx cleared.
  - Byte accepted with idx == MAX_PKT_BYTES: byte not stored; err_oversize set; remaining bytes through load_last are swallowed (load_ready stays 1); slot not committed.
- Output FSM:
  - IDLE: if occupancy>0, go to SEND and load the first beat: out_valid=1, out_sop=1, rd_off=0.
  - SEND: out_data = bytes rd_off..rd_off+WIN_BYTES-1; bytes beyond length are driven 0.
    - out_eop = (rd_off+WIN_BYTES ≥ len).
    - out_empty = rd_off+WIN_BYTES−len on eop, else 0.
  - Beat held (data, sop, eop, empty all stable) while out_valid & !out_ready.
  - Accepted beat (valid&ready), non-eop: rd_off += WIN_BYTES; sop=0.
  - Accepted beat, eop:
    - slot freed (rd ptr++, occupancy−−); pkt_sent_cnt++; out_valid=0;
    - if cfg_gap==0 → IDLE, else → GAP with counter=cfg_gap.
  - GAP: out_valid=0; counter decrements each cycle; → IDLE when it reaches 1.
- Latency:
  - load_last accepted at edge N, empty buffer → out_valid high after edge N+1.
  - Minimum spacing is one IDLE cycle between an eop accept and the next sop (cfg_gap=0); cfg_gap=G gives G+1 idle cycles.
- Simultaneous events:
  - Commit and free on the same edge: occupancy unchanged; load_ready evaluated from the registered occupancy.
  - With a full buffer, load_ready rises the cycle after the freeing eop.
- Widths:
  - Lengths are 16-bit; the rd_off compare is done in 17 bits to avoid wrap.
  - Pointers wrap modulo PKT_SLOTS.
- Packets of 1..WIN_BYTES bytes produce a single beat with sop=eop=1.

Test Plan:
- Single beat: load 60-byte packet 0x00..0x3B, WIN_BYTES=16, out_ready=1 → 4 beats:
  - beat 0: sop=1, bytes 0x00..0x0F;
  - beat 3: eop=1, empty=4, bytes 0x30..0x3B, upper 4 bytes 0;
  - pkt_sent_cnt=1.
- Backpressure: same packet, out_ready toggled 1,0,0,1,… → every beat held stable while stalled; no beat duplicated or lost; order unchanged.
- Full buffer:
  - load 5 packets of 64 B with out_ready=0 → load_ready drops after the 4th load_last.
  - raise out_ready → load_ready returns the cycle after the first eop accept.
  - all 5 packets delivered in order with 1-byte tags 1..5 intact.
- Gap: cfg_gap=3, two queued 16-B packets → each is a single sop/eop beat; exactly 4 idle cycles between the eop accept and the next sop.
- Oversize: load 1600 bytes then load_last, followed by a 64-B packet → err_oversize=1; only the 64-B packet is emitted; pkt_sent_cnt=1.
- Reset mid-packet: assert reset during beat 2 of a 128-B packet → next cycle out_valid=0, occupancy=0, err_oversize=0; a following 60-B load streams correctly starting with sop.
